// File: rtl/tinymips_pkg.sv
// Shared TinyMIPS constants: instruction lane indices, field positions and one-hot
// irwrite strobes, used by the instruction-register stage.
package tinymips_pkg;

   localparam int LANE0 = 0;
   localparam int LANE1 = 1;
   localparam int LANE2 = 2;
   localparam int LANE3 = 3;
   localparam int NUM_LANES = 4;

   localparam int OP_MSB  = 31;
   localparam int OP_LSB  = 26;
   localparam int RS_MSB  = 25;
   localparam int RS_LSB  = 21;
   localparam int RT_MSB  = 20;
   localparam int RT_LSB  = 16;
   localparam int RD_MSB  = 15;
   localparam int RD_LSB  = 11;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;

   localparam logic [3:0] IRW_LANE0 = 4'b0001;
   localparam logic [3:0] IRW_LANE1 = 4'b0010;
   localparam logic [3:0] IRW_LANE2 = 4'b0100;
   localparam logic [3:0] IRW_LANE3 = 4'b1000;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // True when more than one strobe bit is set.
   function automatic logic is_multi_hot(input logic [3:0] mask);
      return (mask & (mask - 4'd1)) != 4'd0;
   endfunction

endpackage

// File: rtl/ir_strobe_delay.sv
// MEM_LAT-deep pipe of 4-bit irwrite masks that lines strobes up with memdata.
// MEM_LAT=0 is a pure wire; clr discards every pending strobe.
module ir_strobe_delay #(
   parameter int MEM_LAT = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic [3:0] strobe,
   output logic [3:0] strobe_d
);

   generate
      if (MEM_LAT == 0) begin : g_bypass
         logic unused_ctrl;
         assign unused_ctrl = ^{clk, rst_n, clr};
         assign strobe_d    = strobe;
      end else begin : g_pipe
         logic [3:0] pipe [MEM_LAT];

         // NOTE: the pipe holds control strobes, so every stage is reset; data-only
         // storage would normally be left unreset.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int k = 0; k < MEM_LAT; k++) pipe[k] <= 4'b0000;
            end else if (clr) begin
               for (int k = 0; k < MEM_LAT; k++) pipe[k] <= 4'b0000;
            end else begin
               // NOTE: non-blocking assignments make every stage sample the old value
               // of its predecessor, giving a true shift rather than a fall-through.
               pipe[0] <= strobe;
               for (int k = 1; k < MEM_LAT; k++) pipe[k] <= pipe[k-1];
            end
         end

         assign strobe_d = pipe[MEM_LAT-1];
      end
   endgenerate

endmodule

// File: rtl/instr_capture_reg.sv
// Instruction register: assembles a 32-bit instruction from four latency-aligned
// byte reads. Optional protocol checking is enabled with IR_PROTOCOL_CHECK_EN.
module instr_capture_reg
   import tinymips_pkg::*;
#(
   parameter int          MEM_LAT     = 0,
   parameter logic [31:0] RESET_INSTR = NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  irwrite,
   input  logic [7:0]  memdata,
   input  logic        flush,
   output logic [31:0] instr,
   output logic [5:0]  op,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [15:0] imm,
   output logic        instr_valid,
   output logic        err
);

   logic [3:0] wr_d;
   logic [3:0] lane_we;
   logic [3:0] loaded;
   logic [3:0] loaded_next;

   ir_strobe_delay #(.MEM_LAT(MEM_LAT)) u_delay (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (flush),
      .strobe   (irwrite),
      .strobe_d (wr_d)
   );

`ifdef IR_PROTOCOL_CHECK_EN
   logic proto_err;

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which is what would otherwise infer a latch.
   always_comb begin
      lane_we   = wr_d;
      proto_err = 1'b0;
      if (is_multi_hot(wr_d)) begin
         lane_we   = 4'b0000;
         proto_err = 1'b1;
      end else begin
         for (int i = 1; i < NUM_LANES; i++)
            if (wr_d[i] && !loaded[i-1]) proto_err = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  err <= 1'b0;
      else if (proto_err && !flush) err <= 1'b1;
   end
`else
   assign lane_we = wr_d;
   assign err     = 1'b0;
`endif

   // A lane-0 load starts a new instruction; other lanes accumulate.
   assign loaded_next = lane_we[LANE0] ? IRW_LANE0 : (loaded | lane_we);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr       <= RESET_INSTR;
         loaded      <= 4'b0000;
         instr_valid <= 1'b0;
      end else if (flush) begin
         instr       <= RESET_INSTR;
         loaded      <= 4'b0000;
         instr_valid <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_LANES; i++)
            if (lane_we[i]) instr[8*i +: 8] <= memdata;
         loaded      <= loaded_next;
         instr_valid <= (loaded_next == 4'b1111);
      end
   end

   // Opcode bypass lets DECODE see the top byte in the cycle it arrives.
   assign op  = lane_we[LANE3] ? memdata[7:2] : instr[OP_MSB:OP_LSB];
   assign rs  = instr[RS_MSB:RS_LSB];
   assign rt  = instr[RT_MSB:RT_LSB];
   assign rd  = instr[RD_MSB:RD_LSB];
   assign imm = instr[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_instr_capture_reg.sv
// Directed bench for instr_capture_reg: one DUT at MEM_LAT=0 and one at MEM_LAT=1,
// covering assembly, opcode bypass, flush, async reset and multi-hot strobes.
module tb_instr_capture_reg;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  irw0, irw1;
   logic [7:0]  md0, md1;
   logic        fl0, fl1;
   logic [31:0] instr0, instr1;
   logic [5:0]  op0, op1;
   logic [4:0]  rs0, rt0, rd0, rs1, rt1, rd1;
   logic [15:0] imm0, imm1;
   logic        val0, val1, err0, err1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   instr_capture_reg #(.MEM_LAT(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .irwrite(irw0), .memdata(md0), .flush(fl0),
      .instr(instr0), .op(op0), .rs(rs0), .rt(rt0), .rd(rd0), .imm(imm0),
      .instr_valid(val0), .err(err0)
   );

   instr_capture_reg #(.MEM_LAT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .irwrite(irw1), .memdata(md1), .flush(fl1),
      .instr(instr1), .op(op1), .rs(rs1), .rt(rt1), .rd(rd1), .imm(imm1),
      .instr_valid(val1), .err(err1)
   );

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Four consecutive lane writes on the zero-latency DUT.
   task automatic fetch0(input logic [31:0] word);
      for (int i = 0; i < 4; i++) begin
         irw0 = 4'(1 << i);
         md0  = word[8*i +: 8];
         step();
      end
      irw0 = 4'b0000;
      md0  = 8'h00;
   endtask

   // Four lane strobes on the one-cycle-latency DUT, data trailing by one cycle.
   task automatic fetch1(input logic [31:0] word);
      for (int i = 0; i < 5; i++) begin
         irw1 = (i < 4) ? 4'(1 << i) : 4'b0000;
         md1  = (i > 0) ? word[8*(i-1) +: 8] : 8'h00;
         step();
      end
      irw1 = 4'b0000;
      md1  = 8'h00;
   endtask

   initial begin
      rst_n = 1'b0;
      irw0 = 4'b0000; irw1 = 4'b0000;
      md0  = 8'h00;   md1  = 8'h00;
      fl0  = 1'b0;    fl1  = 1'b0;
      #1;
      check("rst_instr0", instr0, 32'h0000_0000);
      check("rst_valid0", {31'd0, val0}, 32'd0);
      check("rst_err0",   {31'd0, err0}, 32'd0);
      check("rst_instr1", instr1, 32'h0000_0000);
      #11 rst_n = 1'b1;
      step();

      // MEM_LAT=0 assembly of 32'h2008_0020
      irw0 = 4'b0001; md0 = 8'h20; step();
      irw0 = 4'b0010; md0 = 8'h00; step();
      irw0 = 4'b0100; md0 = 8'h08; step();
      check("l0_partial_valid", {31'd0, val0}, 32'd0);
      check("l0_partial_instr", instr0, 32'h0008_0020);
      irw0 = 4'b1000; md0 = 8'h20; #1;
      check("l0_op_bypass", {26'd0, op0}, 32'h08);
      step();
      irw0 = 4'b0000; md0 = 8'h00; #1;
      check("l0_instr", instr0, 32'h2008_0020);
      check("l0_valid", {31'd0, val0}, 32'd1);
      check("l0_op",    {26'd0, op0}, 32'h08);
      check("l0_rs",    {27'd0, rs0}, 32'h00);
      check("l0_rt",    {27'd0, rt0}, 32'h08);
      check("l0_rd",    {27'd0, rd0}, 32'h00);
      check("l0_imm",   {16'd0, imm0}, 32'h0020);
      step();

      // MEM_LAT=1: data trails strobes; opcode bypass ahead of the register
      irw1 = 4'b0001; md1 = 8'h00; step();
      irw1 = 4'b0010; md1 = 8'h20; step();
      irw1 = 4'b0100; md1 = 8'h00; step();
      irw1 = 4'b1000; md1 = 8'h08; step();
      irw1 = 4'b0000; md1 = 8'h8C; #1;
      check("l1_op_bypass",  {26'd0, op1}, 32'h23);
      check("l1_pre_instr",  instr1, 32'h0008_0020);
      check("l1_pre_valid",  {31'd0, val1}, 32'd0);
      step();
      md1 = 8'h00; #1;
      check("l1_instr", instr1, 32'h8C08_0020);
      check("l1_valid", {31'd0, val1}, 32'd1);
      check("l1_op",    {26'd0, op1}, 32'h23);

      // Flush with lane-2 strobe pending in the delay line
      irw1 = 4'b0001; md1 = 8'h00; step();
      irw1 = 4'b0010; md1 = 8'h03; step();
      irw1 = 4'b0100; md1 = 8'h00; step();
      irw1 = 4'b0000; md1 = 8'h55; fl1 = 1'b1; step();
      fl1 = 1'b0; md1 = 8'hFF; #1;
      check("fl_instr", instr1, 32'h0000_0000);
      check("fl_valid", {31'd0, val1}, 32'd0);
      step();
      check("fl_pending_dropped", instr1, 32'h0000_0000);
      md1 = 8'h00;
      fetch1(32'h1000_0003);
      check("fl_refetch_instr", instr1, 32'h1000_0003);
      check("fl_refetch_valid", {31'd0, val1}, 32'd1);
      check("fl_refetch_op",    {26'd0, op1}, 32'h04);

      // Async reset mid-fetch; dut1 also holds a pending lane-0 strobe
      irw0 = 4'b0001; md0 = 8'h11; step();
      irw0 = 4'b0010; md0 = 8'h22; irw1 = 4'b0001; step();
      irw0 = 4'b0000; md0 = 8'h00; irw1 = 4'b0000; md1 = 8'hFF;
      #1 rst_n = 1'b0;
      #1;
      check("mrst_instr0", instr0, 32'h0000_0000);
      check("mrst_valid0", {31'd0, val0}, 32'd0);
      check("mrst_instr1", instr1, 32'h0000_0000);
      check("mrst_valid1", {31'd0, val1}, 32'd0);
      #1 rst_n = 1'b1;
      step();
      check("mrst_late_data_ignored", instr1, 32'h0000_0000);
      md1 = 8'h00;
      fetch0(32'h0800_0004);
      #1;
      check("mrst_refetch_instr", instr0, 32'h0800_0004);
      check("mrst_refetch_op",    {26'd0, op0}, 32'h02);
      check("mrst_refetch_valid", {31'd0, val0}, 32'd1);

      // Multi-hot strobe
      irw0 = 4'b0011; md0 = 8'hAA; step();
      irw0 = 4'b0000; md0 = 8'h00; #1;
`ifdef IR_PROTOCOL_CHECK_EN
      check("mh_instr_unchanged", instr0, 32'h0800_0004);
      check("mh_err_set", {31'd0, err0}, 32'd1);
      fetch0(32'h2008_0020);
      #1;
      check("mh_err_sticky", {31'd0, err0}, 32'd1);
      check("mh_next_instr", instr0, 32'h2008_0020);
`else
      check("mh_imm", {16'd0, imm0}, 32'h0000_AAAA);
      check("mh_err_zero", {31'd0, err0}, 32'd0);
`endif
      check("end_err1", {31'd0, err1}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_capture_reg.md
Name: instr_capture_reg

Overview:
- Instruction register stage directly upstream of the multicycle controller.
- Assembles a 32-bit MIPS instruction from four byte reads (FETCH1..FETCH4) using the controller's one-hot irwrite strobes.
- Compensates for memory read latency with an internal strobe delay line.
- Feeds op[5:0] back to the controller in time for DECODE, and supplies the register/immediate fields to the datapath.

Parameters:
- MEM_LAT, 0, memory read latency in cycles from memread/irwrite to valid memdata; legal values 0..2.
- RESET_INSTR, 32'h0000_0000, instr value after reset and after flush (a MIPS NOP).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- irwrite  input  4  one-hot byte-lane strobe from the controller; bit i loads lane i.
- memdata  input  8  byte returned by memory.
- flush  input  1  synchronous abort of the in-progress fetch.
- instr  output  32  assembled instruction register.
- op  output  6  opcode to the controller, including the bypass path.
- rs, rt, rd  output  5 each  instr[25:21], [20:16], [15:11].
- imm  output  16  instr[15:0].
- instr_valid  output  1  all four lanes loaded since the last lane-0 load.
- err  output  1  sticky protocol error; see Optional Feature.

Behaviour:
- Reset (async, rst_n=0):
  - instr=RESET_INSTR, instr_valid=0, err=0.
  - Delay line cleared; loaded mask=4'b0000.
- Lane mapping:
  - Lane 0 = instr[7:0], lane 1 = [15:8], lane 2 = [23:16], lane 3 = [31:24] (little-endian).
  - FETCH1 supplies the least significant byte.
- Delay line:
  - irwrite passes through MEM_LAT register stages, giving a pending mask wr_d.
  - With MEM_LAT=0, wr_d=irwrite combinationally.
- Lane write: at each rising edge, every lane i with wr_d[i]=1 loads memdata.
- Loaded mask, updated at the same edge as the lane write:
  - wr_d[0]=1: loaded <= 4'b0001. Lane 0 starts a new instruction.
  - Otherwise: loaded <= loaded | wr_d.
- instr_valid is registered: it equals (loaded==4'b1111) and is high from the edge that wrote the last lane.
- op bypass:
  - op = memdata[7:2] when wr_d[3]=1; otherwise op = instr[31:26].
  - This lets DECODE see the opcode in the same cycle the last byte arrives when MEM_LAT>=1.
  - rs/rt/rd/imm never bypass; they are valid only once instr_valid=1.
- Out-of-order lanes: a lane written while its lower lane is not yet loaded is still written. The loaded mask keeps it and instr_valid stays 0 until the mask is complete.
- Simultaneous events:
  - flush has priority over any same-cycle lane write.
  - flush clears the delay line and loaded, sets instr_valid=0, and sets instr=RESET_INSTR.
- Reset mid-fetch:
  - All pending strobes in the delay line are discarded.
  - memdata arriving after reset release is ignored.
- Held irwrite: the same lane asserted on consecutive cycles rewrites that lane each cycle (last value wins).

Optional Feature:
- Macro: IR_PROTOCOL_CHECK_EN.
- Defined:
  - A non-one-hot nonzero wr_d is ignored (no lane written, loaded unchanged) and sets err.
  - Writing lane i>0 while loaded[i-1]=0 also sets err.
  - err clears only on reset.
- Undefined: a multi-hot wr_d writes every selected lane with memdata, and err is tied to 0.

Decomposition:
- Shared package (tinymips_pkg):
  - Lane index constants LANE0..LANE3.
  - Field bit positions OP_MSB/OP_LSB, RS, RT, RD, IMM.
  - IRW_LANE0..IRW_LANE3 one-hot constants.
  - NOP_INSTR.
- Sub-module ir_strobe_delay: parameterised MEM_LAT-deep pipe of 4-bit strobe masks with synchronous clear (driven by flush) and async reset.

Test Plan:
- MEM_LAT=0: irwrite 0001,0010,0100,1000 with memdata 8'h20,8'h00,8'h08,8'h20 on consecutive cycles → instr=32'h2008_0020 after the 4th edge; instr_valid=1; op=6'b001000.
- MEM_LAT=1: same sequence, memdata lagging one cycle → in the cycle memdata=8'h8C arrives with wr_d[3]=1, op=6'b100011 before instr updates; at the next edge instr[31:24]=8'h8C.
- flush asserted with wr_d=0100 pending, then a new 4-lane fetch of 32'h1000_0003 → instr=32'h0000_0000 and instr_valid=0 after the flush edge; instr=32'h1000_0003 and instr_valid=1 after the 4th lane.
- rst_n pulsed low mid-fetch after two lanes → all outputs return to reset values asynchronously; the following full fetch of 32'h0800_0004 yields op=6'b000010.
- IR_PROTOCOL_CHECK_EN defined: irwrite=0011 → no lane changes; err=1 and stays 1 through a subsequent valid fetch.
- Macro undefined: irwrite=0011 with memdata=8'hAA → instr[15:0]=16'hAAAA; err=0.
